dcache_mem_bridge: RTL and testbench

- Responder for the dual-port dcache request interface driven by the MMU. It is an uncached data-side back end that replaces the dcache in bring-up and uncached-only builds.
- Accepts one request per handshake, carrying a p0 access and an optional p1 access that share tag/index. The pair is serialised into one or two single-beat transactions on a simple req/addr_ok/data_ok memory bus.
- Returns both read words with one data_ok pulse.
- Cache-maintenance ops are acknowledged with no memory traffic.

---
 rtl/dcache_mem_bridge_pkg.sv | 31 +++
 rtl/dcache_mem_req_latch.sv | 81 ++++++++
 rtl/dcache_mem_bridge.sv | 136 +++++++++++++
 tb/tb_dcache_mem_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_mem_bridge_pkg.sv
// Shared definitions for the uncached dcache memory bridge.
//   bridge_state_t : serialisation FSM states (IDLE, P0_REQ, P0_WAIT, P1_REQ, P1_WAIT, RESP)
//   OP_READ/OP_WRITE : op encodings (op[1] is don't-care); op[2]=1 is a cacop
package dcache_mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        P0_REQ,
        P0_WAIT,
        P1_REQ,
        P1_WAIT,
        RESP
    } bridge_state_t;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b001;

    // Cache-maintenance ops are any encoding with op[2] set.
    function automatic logic is_cacop(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op & 3'b101) == OP_READ;
    endfunction

    function automatic logic op_is_write(input logic [2:0] op);
        return (op & 3'b101) == OP_WRITE;
    endfunction

endpackage

// File: rtl/dcache_mem_req_latch.sv
// mem_req_latch: holds the fields of an accepted p0/p1 request pair and
// steers the active port onto the memory request bus.
//   clk, reset        : clock, synchronous active-high reset (clears all fields)
//   load              : capture all request inputs this cycle
//   sel_p1            : 0 = present p0 fields, 1 = present p1 fields
//   we, tag, index, pX_offset, pX_size, pX_wstrb, pX_wdata : request inputs
//   mem_we, mem_addr, mem_size, mem_wstrb, mem_wdata       : memory bus fields
module mem_req_latch
    import dcache_mem_bridge_pkg::*;
#(
    parameter int TAG_W = 20,
    parameter int IDX_W = 8,
    parameter int OFF_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             sel_p1,
    input  logic             we,
    input  logic [TAG_W-1:0] tag,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] p0_offset,
    input  logic [OFF_W-1:0] p1_offset,
    input  logic [1:0]       p0_size,
    input  logic [1:0]       p1_size,
    input  logic [3:0]       p0_wstrb,
    input  logic [3:0]       p1_wstrb,
    input  logic [31:0]      p0_wdata,
    input  logic [31:0]      p1_wdata,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [1:0]       mem_size,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata
);

    logic             r_we;
    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_index;
    logic [OFF_W-1:0] r_p0_offset, r_p1_offset;
    logic [1:0]       r_p0_size, r_p1_size;
    logic [3:0]       r_p0_wstrb, r_p1_wstrb;
    logic [31:0]      r_p0_wdata, r_p1_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_tag       <= '0;
            r_index     <= '0;
            r_p0_offset <= '0;
            r_p1_offset <= '0;
            r_p0_size   <= '0;
            r_p1_size   <= '0;
            r_p0_wstrb  <= '0;
            r_p1_wstrb  <= '0;
            r_p0_wdata  <= '0;
            r_p1_wdata  <= '0;
        end else if (load) begin
            r_we        <= we;
            r_tag       <= tag;
            r_index     <= index;
            r_p0_offset <= p0_offset;
            r_p1_offset <= p1_offset;
            r_p0_size   <= p0_size;
            r_p1_size   <= p1_size;
            r_p0_wstrb  <= p0_wstrb;
            r_p1_wstrb  <= p1_wstrb;
            r_p0_wdata  <= p0_wdata;
            r_p1_wdata  <= p1_wdata;
        end
    end

    // Fields come straight from registers, so they cannot move while a
    // request is held waiting for mem_addr_ok.
    assign mem_we    = r_we;
    assign mem_addr  = {r_tag, r_index, sel_p1 ? r_p1_offset : r_p0_offset};
    assign mem_size  = sel_p1 ? r_p1_size  : r_p0_size;
    assign mem_wstrb = sel_p1 ? r_p1_wstrb : r_p0_wstrb;
    assign mem_wdata = sel_p1 ? r_p1_wdata : r_p0_wdata;

endmodule

// File: rtl/dcache_mem_bridge.sv
// dcache_mem_bridge: uncached responder for the dual-port dcache request
// interface. An accepted p0(+p1) pair is issued as one or two single-beat
// memory transactions; both read words return with a single data_ok pulse.
// Cacops are acknowledged without touching memory.
//   clk, reset                 : clock, synchronous active-high reset
//   p0_valid, p1_valid, op, tag, index, pX_* , uncached : request side
//   addr_ok, data_ok, p0_rdata, p1_rdata                 : response side
//   mem_req, mem_we, mem_addr, mem_size, mem_wstrb, mem_wdata : memory request
//   mem_addr_ok, mem_data_ok, mem_rdata                  : memory response
module dcache_mem_bridge
    import dcache_mem_bridge_pkg::*;
#(
    parameter int TAG_W = 20,
    parameter int IDX_W = 8,
    parameter int OFF_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_valid,
    input  logic             p1_valid,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] tag,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] p0_offset,
    input  logic [OFF_W-1:0] p1_offset,
    input  logic [3:0]       p0_wstrb,
    input  logic [3:0]       p1_wstrb,
    input  logic [31:0]      p0_wdata,
    input  logic [31:0]      p1_wdata,
    input  logic [1:0]       p0_size,
    input  logic [1:0]       p1_size,
    input  logic             uncached,
    output logic             addr_ok,
    output logic             data_ok,
    output logic [31:0]      p0_rdata,
    output logic [31:0]      p1_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [1:0]       mem_size,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata
);

    bridge_state_t state;
    logic          has_p1;
    logic          rd_op;
    logic          accept;
    logic          unused_uncached;

    // Every access is treated as uncached.
    assign unused_uncached = uncached;

    assign addr_ok = (state == IDLE);
    assign accept  = addr_ok && p0_valid;
    assign data_ok = (state == RESP);
    assign mem_req = (state == P0_REQ) || (state == P1_REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            has_p1   <= 1'b0;
            rd_op    <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (p0_valid) begin
                        has_p1   <= p1_valid && !is_cacop(op);
                        rd_op    <= op_is_read(op);
                        // Clearing here makes cacops and p0-only requests return 0.
                        p0_rdata <= '0;
                        p1_rdata <= '0;
                        state    <= is_cacop(op) ? RESP : P0_REQ;
                    end
                end
                P0_REQ: begin
                    if (mem_addr_ok) state <= P0_WAIT;
                end
                P0_WAIT: begin
                    if (mem_data_ok) begin
                        p0_rdata <= rd_op ? mem_rdata : '0;
                        state    <= has_p1 ? P1_REQ : RESP;
                    end
                end
                P1_REQ: begin
                    if (mem_addr_ok) state <= P1_WAIT;
                end
                P1_WAIT: begin
                    if (mem_data_ok) begin
                        p1_rdata <= rd_op ? mem_rdata : '0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_req_latch #(
        .TAG_W (TAG_W),
        .IDX_W (IDX_W),
        .OFF_W (OFF_W)
    ) u_req_latch (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .sel_p1    ((state == P1_REQ) || (state == P1_WAIT)),
        .we        (op[0]),
        .tag       (tag),
        .index     (index),
        .p0_offset (p0_offset),
        .p1_offset (p1_offset),
        .p0_size   (p0_size),
        .p1_size   (p1_size),
        .p0_wstrb  (p0_wstrb),
        .p1_wstrb  (p1_wstrb),
        .p0_wdata  (p0_wdata),
        .p1_wdata  (p1_wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_size  (mem_size),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Self-checking bench for dcache_mem_bridge: transaction-level model plus
// directed tests with literal expectations.
module tb_dcache_mem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [19:0] tag = '0;
    logic [7:0]  index = '0;
    logic [3:0]  p0_offset = '0, p1_offset = '0;
    logic [3:0]  p0_wstrb = '0, p1_wstrb = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic [1:0]  p0_size = '0, p1_size = '0;
    logic        uncached = 1'b1;
    logic        addr_ok, data_ok;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    dcache_mem_bridge #(.TAG_W(20), .IDX_W(8), .OFF_W(4)) dut (
        .clk(clk), .reset(reset), .p0_valid(p0_valid), .p1_valid(p1_valid), .op(op),
        .tag(tag), .index(index), .p0_offset(p0_offset), .p1_offset(p1_offset),
        .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_size(p0_size), .p1_size(p1_size), .uncached(uncached),
        .addr_ok(addr_ok), .data_ok(data_ok), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beats[$];
    bit          m_busy = 0, m_outst = 0, m_resp = 0;
    int          m_nbeat = 0;
    logic [31:0] m_p0 = '0, m_p1 = '0;

    initial forever begin
        beat_t b;
        logic [31:0] v;
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_busy = 0; m_outst = 0; m_resp = 0; m_nbeat = 0;
            m_p0 = '0; m_p1 = '0;
            beats.delete();
        end else if (m_resp) begin
            m_resp = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (p0_valid) begin
                m_busy = 1; m_nbeat = 0; m_p0 = '0; m_p1 = '0;
                if (op[2]) begin
                    m_resp = 1;
                end else begin
                    b.addr  = (32'(tag) << 12) | (32'(index) << 4) | 32'(p0_offset);
                    b.we    = op[0]; b.size = p0_size; b.wstrb = p0_wstrb; b.wdata = p0_wdata;
                    beats.push_back(b);
                    if (p1_valid) begin
                        b.addr  = (32'(tag) << 12) | (32'(index) << 4) | 32'(p1_offset);
                        b.size  = p1_size; b.wstrb = p1_wstrb; b.wdata = p1_wdata;
                        beats.push_back(b);
                    end
                end
            end
        end else if (m_outst) begin
            if (mem_data_ok) begin
                v = beats[0].we ? 32'h0 : mem_rdata;
                if (m_nbeat == 0) m_p0 = v; else m_p1 = v;
                m_nbeat++;
                void'(beats.pop_front());
                m_outst = 0;
                if (beats.size() == 0) m_resp = 1;
            end
        end else if (beats.size() > 0 && mem_addr_ok) begin
            m_outst = 1;
        end
    end

    // ---------------- compare + monitor (negedge) ----------------
    logic [31:0] addr_log[$];
    int          dok_cnt = 0, dok_cyc = -1, req_cycles = 0, first_req = -1;
    logic [31:0] last_p0 = '0, last_p1 = '0;

    initial forever begin
        bit e_req;
        @(negedge clk);
        if (chk_en) begin
            e_req = m_busy && !m_resp && beats.size() > 0 && !m_outst;
            chk("addr_ok", 32'(addr_ok), 32'(!m_busy));
            chk("data_ok", 32'(data_ok), 32'(m_resp));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            if (e_req) begin
                chk("mem_addr",  mem_addr,         beats[0].addr);
                chk("mem_we",    32'(mem_we),      32'(beats[0].we));
                chk("mem_size",  32'(mem_size),    32'(beats[0].size));
                chk("mem_wstrb", 32'(mem_wstrb),   32'(beats[0].wstrb));
                chk("mem_wdata", mem_wdata,        beats[0].wdata);
            end
            if (m_resp) begin
                chk("p0_rdata", p0_rdata, m_p0);
                chk("p1_rdata", p1_rdata, m_p1);
            end
            if (mem_req) begin
                req_cycles++;
                if (first_req < 0) first_req = cyc;
                if (mem_addr_ok) addr_log.push_back(mem_addr);
            end
            if (data_ok) begin
                dok_cnt++; dok_cyc = cyc; last_p0 = p0_rdata; last_p1 = p1_rdata;
            end
        end
    end

    // ---------------- memory responder ----------------
    bit          resp_en = 1;
    int          cfg_aw = 0, cfg_dw = 0, acnt = 0, dcnt = 0;
    bit          pend = 0;
    logic [31:0] rq[$];

    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin pend = 0; acnt = cfg_aw; end
        if (resp_en) begin
            mem_addr_ok = 0;
            mem_data_ok = 0;
            if (pend) begin
                if (dcnt == 0) begin
                    mem_data_ok = 1;
                    if (rq.size() != 0) mem_rdata = rq.pop_front();
                    else mem_rdata = 32'hBAD0_0000;
                    pend = 0;
                end else dcnt--;
            end else if (mem_req) begin
                if (acnt == 0) begin
                    mem_addr_ok = 1; pend = 1; dcnt = cfg_dw; acnt = cfg_aw;
                end else acnt--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int acc_cyc = 0;

    task automatic set_mem(input int aw, input int dw);
        cfg_aw = aw; cfg_dw = dw; acnt = aw;
    endtask

    task automatic clear_log();
        addr_log.delete();
        dok_cnt = 0; dok_cyc = -1; req_cycles = 0; first_req = -1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [19:0] tg, input logic [7:0] ix,
                         input logic [3:0] off0, input logic [3:0] off1, input logic p1v,
                         input logic [1:0] sz0, input logic [3:0] ws0, input logic [31:0] wd0,
                         input logic [1:0] sz1, input logic [3:0] ws1, input logic [31:0] wd1);
        bit done = 0;
        op = o; tag = tg; index = ix; p0_offset = off0; p1_offset = off1;
        p0_size = sz0; p0_wstrb = ws0; p0_wdata = wd0;
        p1_size = sz1; p1_wstrb = ws1; p1_wdata = wd1;
        p0_valid = 1; p1_valid = p1v;
        for (int i = 0; i < 50 && !done; i++) begin
            if (addr_ok) begin acc_cyc = cyc; done = 1; end
            tick();
        end
        p0_valid = 0; p1_valid = 0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (data_ok) done = 1;
            tick();
        end
        if (!done) chk("data_ok_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_mem_req();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (mem_req) done = 1; else tick();
        end
        if (!done) chk("mem_req_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        repeat (3) tick();
        reset = 0;
        chk_en = 1;
        chk("rst_addr_ok", 32'(addr_ok), 32'd1);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        tick();

        // single word read, 2 data wait cycles
        set_mem(0, 2); rq.push_back(32'hDEADBEEF); clear_log();
        issue(3'b000, 20'h1C000, 8'h12, 4'h4, 4'h0, 1'b0, 2'd2, 4'hF, 32'h0, 2'd2, 4'hF, 32'h0);
        wait_done();
        chk("t1_ntrans", 32'(addr_log.size()), 32'd1);
        if (addr_log.size() > 0) chk("t1_addr", addr_log[0], 32'h1C000124);
        chk("t1_ndok", 32'(dok_cnt), 32'd1);
        chk("t1_p0", last_p0, 32'hDEADBEEF);
        chk("t1_req_lat", 32'(first_req), 32'(acc_cyc + 1));
        tick();

        // dual read
        set_mem(0, 0); rq.push_back(32'h11111111); rq.push_back(32'h22222222); clear_log();
        issue(3'b000, 20'h1C000, 8'h12, 4'h0, 4'h8, 1'b1, 2'd2, 4'hF, 32'h0, 2'd2, 4'hF, 32'h0);
        wait_done();
        chk("t2_ntrans", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() > 1) begin
            chk("t2_addr0", addr_log[0], 32'h1C000120);
            chk("t2_addr1", addr_log[1], 32'h1C000128);
        end
        chk("t2_ndok", 32'(dok_cnt), 32'd1);
        chk("t2_p0", last_p0, 32'h11111111);
        chk("t2_p1", last_p1, 32'h22222222);
        tick();

        // cacop with p1_valid: no memory traffic, response next cycle
        clear_log();
        issue(3'b101, 20'h1C000, 8'h12, 4'h0, 4'h8, 1'b1, 2'd2, 4'hF, 32'h0, 2'd2, 4'hF, 32'h0);
        wait_done();
        chk("t4_req_cycles", 32'(req_cycles), 32'd0);
        chk("t4_dok_lat", 32'(dok_cyc), 32'(acc_cyc + 1));
        chk("t4_p0", last_p0, 32'd0);
        chk("t4_p1", last_p1, 32'd0);
        tick();

        // byte store with mem_addr_ok held off 3 cycles
        set_mem(3, 0); clear_log();
        issue(3'b001, 20'h1C000, 8'h12, 4'h2, 4'h0, 1'b0, 2'd0, 4'h4, 32'h00AB0000, 2'd0, 4'h0, 32'h0);
        wait_done();
        chk("t3_req_cycles", 32'(req_cycles), 32'd4);
        chk("t3_ntrans", 32'(addr_log.size()), 32'd1);
        chk("t3_ndok", 32'(dok_cnt), 32'd1);
        chk("t3_p0", last_p0, 32'd0);
        tick();

        // p1_valid without p0_valid is not accepted
        clear_log();
        p1_valid = 1; tag = 20'h0F0F0;
        repeat (3) begin
            chk("t5_addr_ok", 32'(addr_ok), 32'd1);
            tick();
        end
        p1_valid = 0;
        tick();
        chk("t5_req_cycles", 32'(req_cycles), 32'd0);
        chk("t5_ndok", 32'(dok_cnt), 32'd0);

        // request presented during P0_WAIT is refused and not latched
        set_mem(0, 3); rq.push_back(32'h5A5A5A5A); clear_log();
        issue(3'b000, 20'h00ABC, 8'h34, 4'hC, 4'h0, 1'b0, 2'd2, 4'hF, 32'h0, 2'd2, 4'hF, 32'h0);
        for (int i = 0; i < 20 && addr_log.size() == 0; i++) tick();
        tick();
        op = 3'b001; tag = 20'hFFFFF; index = 8'hFF; p0_offset = 4'h0; p0_valid = 1;
        chk("t5_busy_addr_ok", 32'(addr_ok), 32'd0);
        tick();
        chk("t5_busy_addr_ok2", 32'(addr_ok), 32'd0);
        tick();
        p0_valid = 0;
        wait_done();
        chk("t5_ntrans", 32'(addr_log.size()), 32'd1);
        if (addr_log.size() > 0) chk("t5_addr", addr_log[0], 32'h00ABC34C);
        chk("t5_p0", last_p0, 32'h5A5A5A5A);
        tick();

        // reset during P1_WAIT, then a stray mem_data_ok
        resp_en = 0; mem_addr_ok = 0; mem_data_ok = 0; clear_log();
        issue(3'b000, 20'h12345, 8'h67, 4'h0, 4'h4, 1'b1, 2'd2, 4'hF, 32'h0, 2'd2, 4'hF, 32'h0);
        wait_mem_req();
        mem_addr_ok = 1; tick(); mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'h33333333; tick(); mem_data_ok = 0;
        wait_mem_req();
        mem_addr_ok = 1; tick(); mem_addr_ok = 0;
        reset = 1; tick(); reset = 0;
        chk("t6_addr_ok", 32'(addr_ok), 32'd1);
        chk("t6_data_ok", 32'(data_ok), 32'd0);
        chk("t6_p0", p0_rdata, 32'd0);
        chk("t6_p1", p1_rdata, 32'd0);
        mem_data_ok = 1; mem_rdata = 32'h44444444; tick(); mem_data_ok = 0;
        chk("t6_late_data_ok", 32'(data_ok), 32'd0);
        chk("t6_late_mem_req", 32'(mem_req), 32'd0);
        chk("t6_late_p1", p1_rdata, 32'd0);
        tick();
        chk("t6_ndok", 32'(dok_cnt), 32'd0);
        resp_en = 1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
